// File: rtl/hamm_rx_ctrl.sv
// Serial Hamming(7,4) receiver: collects a 7-bit codeword one bit per cycle,
// corrects a single-bit error from the syndrome, and presents the 4 data bits
// through a valid/ready handshake. Also tracks frame, correction and overrun
// statistics.
module hamm_rx_ctrl #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sin,
  input  logic             clr_cnt,
  input  logic             d_ready,
  output logic [3:0]       d_out,
  output logic             d_valid,
  output logic [2:0]       syndrome,
  output logic             err_flag,
  output logic             busy,
  output logic             ovr,
  output logic [CNT_W-1:0] corr_cnt,
  output logic [CNT_W-1:0] frame_cnt
);

  typedef enum logic [1:0] {IDLE, SHIFT, DECODE, HOLD} state_t;

  state_t     state;
  logic [7:1] cw;
  logic [2:0] idx;
  logic [2:0] syn;
  logic [7:1] fixed;

  // Syndrome of the captured codeword and the codeword with the indicated bit flipped
  always_comb begin
    syn[0] = cw[1] ^ cw[3] ^ cw[5] ^ cw[7];
    syn[1] = cw[2] ^ cw[3] ^ cw[6] ^ cw[7];
    syn[2] = cw[4] ^ cw[5] ^ cw[6] ^ cw[7];
    fixed  = cw;
    for (int unsigned i = 1; i <= 7; i++) begin
      if (syn == 3'(i)) fixed[i] = ~cw[i];
    end
  end

  assign busy = (state != IDLE);

  // Frame FSM: bit capture, decode, and output hold under backpressure
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= 3'd1;
      cw       <= '0;
      d_out    <= '0;
      syndrome <= '0;
      err_flag <= 1'b0;
      d_valid  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cw[1] <= sin;
            idx   <= 3'd2;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          cw[idx] <= sin;
          if (idx == 3'd7) begin
            idx   <= 3'd1;
            state <= DECODE;
          end else begin
            idx <= idx + 3'd1;
          end
        end
        DECODE: begin
          d_out    <= {fixed[3], fixed[5], fixed[6], fixed[7]};
          syndrome <= syn;
          err_flag <= (syn != 3'd0);
          d_valid  <= 1'b1;
          state    <= HOLD;
        end
        HOLD: begin
          if (d_ready) begin
            d_valid <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Statistics: clear has priority over any increment or overrun in the same cycle
  always_ff @(posedge clk) begin
    if (rst || clr_cnt) begin
      corr_cnt  <= '0;
      frame_cnt <= '0;
      ovr       <= 1'b0;
    end else begin
      if (start && state != IDLE) ovr <= 1'b1;
      if (state == DECODE) begin
        frame_cnt <= frame_cnt + 1'b1;
        if (syn != 3'd0 && corr_cnt != '1) corr_cnt <= corr_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hamm_rx_ctrl.sv
// Self-checking bench for hamm_rx_ctrl: directed and randomized frames against
// a position-XOR Hamming reference, with an 8-bit and a 2-bit counter instance.
module tb_hamm_rx_ctrl;

  logic clk = 1'b0;
  logic rst, start, sin, clr_cnt, d_ready;
  logic [3:0] d_out, d_out2;
  logic [2:0] syndrome, syndrome2;
  logic d_valid, d_valid2, err_flag, err_flag2, busy, busy2, ovr, ovr2;
  logic [7:0] corr_cnt, frame_cnt;
  logic [1:0] corr_cnt2, frame_cnt2;

  int vectors = 0;
  int miscompares = 0;

  int frm8 = 0, cor8 = 0, frm2 = 0, cor2 = 0;
  bit ovr_m = 1'b0;
  logic [3:0] e_dout = '0;
  logic [2:0] e_syn = '0;
  bit e_err = 1'b0;

  always #5 clk = ~clk;

  hamm_rx_ctrl #(.CNT_W(8)) u8 (
    .clk(clk), .rst(rst), .start(start), .sin(sin), .clr_cnt(clr_cnt),
    .d_ready(d_ready), .d_out(d_out), .d_valid(d_valid), .syndrome(syndrome),
    .err_flag(err_flag), .busy(busy), .ovr(ovr), .corr_cnt(corr_cnt),
    .frame_cnt(frame_cnt)
  );

  hamm_rx_ctrl #(.CNT_W(2)) u2 (
    .clk(clk), .rst(rst), .start(start), .sin(sin), .clr_cnt(clr_cnt),
    .d_ready(d_ready), .d_out(d_out2), .d_valid(d_valid2), .syndrome(syndrome2),
    .err_flag(err_flag2), .busy(busy2), .ovr(ovr2), .corr_cnt(corr_cnt2),
    .frame_cnt(frame_cnt2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input bit valid, input bit bsy);
    chk({tag, ".d_valid"}, 32'(d_valid), 32'(valid));
    chk({tag, ".busy"}, 32'(busy), 32'(bsy));
    chk({tag, ".d_out"}, 32'(d_out), 32'(e_dout));
    chk({tag, ".syndrome"}, 32'(syndrome), 32'(e_syn));
    chk({tag, ".err_flag"}, 32'(err_flag), 32'(e_err));
    chk({tag, ".ovr"}, 32'(ovr), 32'(ovr_m));
    chk({tag, ".corr_cnt"}, 32'(corr_cnt), 32'(cor8));
    chk({tag, ".frame_cnt"}, 32'(frame_cnt), 32'(frm8));
    chk({tag, ".corr_cnt_w2"}, 32'(corr_cnt2), 32'(cor2));
    chk({tag, ".frame_cnt_w2"}, 32'(frame_cnt2), 32'(frm2));
    chk({tag, ".d_out_w2"}, 32'(d_out2), 32'(e_dout));
  endtask

  function automatic logic [7:1] encode(input logic [3:0] d);
    logic [7:1] c;
    c[3] = d[3]; c[5] = d[2]; c[6] = d[1]; c[7] = d[0];
    c[1] = c[3] ^ c[5] ^ c[7];
    c[2] = c[3] ^ c[6] ^ c[7];
    c[4] = c[5] ^ c[6] ^ c[7];
    return c;
  endfunction

  // Reference: syndrome is the XOR of the positions holding a 1
  task automatic expect_decode(input logic [7:1] cw, input bit clr);
    int s = 0;
    logic [7:1] c = cw;
    for (int i = 1; i <= 7; i++) if (cw[i]) s ^= i;
    if (s != 0) c[s] = ~c[s];
    e_dout = {c[3], c[5], c[6], c[7]};
    e_syn  = s[2:0];
    e_err  = (s != 0);
    if (clr) begin
      frm8 = 0; cor8 = 0; frm2 = 0; cor2 = 0; ovr_m = 1'b0;
    end else begin
      frm8 = (frm8 + 1) % 256;
      frm2 = (frm2 + 1) % 4;
      if (s != 0) begin
        if (cor8 < 255) cor8++;
        if (cor2 < 3) cor2++;
      end
    end
  endtask

  task automatic frame(input string tag, input logic [7:1] cw, input int stall,
                       input int ovr_k, input bit clr_dec);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      start   = (k == 1) || (k == ovr_k);
      sin     = cw[k];
      d_ready = (stall == 0);
    end
    if (ovr_k > 1) ovr_m = 1'b1;
    @(negedge clk);
    chk_all({tag, ".dec"}, 1'b0, 1'b1);
    start = 1'b0; sin = 1'b0; clr_cnt = clr_dec;
    expect_decode(cw, clr_dec);
    @(negedge clk);
    clr_cnt = 1'b0;
    chk_all({tag, ".out"}, 1'b1, 1'b1);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk_all({tag, ".stall"}, 1'b1, 1'b1);
    end
    d_ready = 1'b1;
    @(negedge clk);
    chk_all({tag, ".done"}, 1'b0, 1'b0);
  endtask

  task automatic clear_counts();
    @(negedge clk);
    clr_cnt = 1'b1;
    frm8 = 0; cor8 = 0; frm2 = 0; cor2 = 0; ovr_m = 1'b0;
    @(negedge clk);
    clr_cnt = 1'b0;
    chk_all("clr", 1'b0, 1'b0);
  endtask

  initial begin
    logic [7:1] good;
    logic [7:1] cwv;
    rst = 1'b1; start = 1'b0; sin = 1'b0; clr_cnt = 1'b0; d_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_all("reset", 1'b0, 1'b0);
    rst = 1'b0;

    // Clean frame 0110011 -> 1011
    good = encode(4'b1011);
    chk("encode_ref", 32'(good), 32'(7'b1100110));
    frame("clean", good, 0, 0, 1'b0);
    chk("clean.dout_const", 32'(d_out), 32'hB);

    // Single-bit errors at every position
    for (int p = 1; p <= 7; p++) begin
      cwv = good;
      cwv[p] = ~cwv[p];
      frame("flip", cwv, 0, 0, 1'b0);
      chk("flip.dout_const", 32'(d_out), 32'hB);
      chk("flip.syn_pos", 32'(syndrome), 32'(p));
    end

    // Backpressure for 5 cycles, then immediate next frame
    frame("stall", encode(4'b0110), 5, 0, 1'b0);
    frame("after_stall", encode(4'b1001), 0, 0, 1'b0);

    // Overrun pulse at T+3, then clear
    frame("ovr", encode(4'b0101), 0, 4, 1'b0);
    clear_counts();

    // Randomized frames with 0, 1 or 2 flipped bits and random stalls
    for (int n = 0; n < 24; n++) begin
      int nf, p1, p2;
      cwv = encode(4'($urandom_range(0, 15)));
      nf = $urandom_range(0, 2);
      p1 = $urandom_range(1, 7);
      p2 = ((p1 - 1 + $urandom_range(1, 6)) % 7) + 1;
      if (nf >= 1) cwv[p1] = ~cwv[p1];
      if (nf == 2) cwv[p2] = ~cwv[p2];
      frame("rand", cwv, $urandom_range(0, 3), 0, 1'b0);
    end

    // Saturation / wrap on the 2-bit instance, then clear during DECODE
    clear_counts();
    for (int n = 0; n < 5; n++) begin
      cwv = encode(4'($urandom_range(0, 15)));
      cwv[n + 1] = ~cwv[n + 1];
      frame("sat", cwv, 0, 0, 1'b0);
    end
    chk("sat.corr_w2", 32'(corr_cnt2), 32'd3);
    chk("sat.frame_w2", 32'(frame_cnt2), 32'd1);
    cwv = good;
    cwv[2] = ~cwv[2];
    frame("clr_dec", cwv, 0, 0, 1'b1);

    // Reset in SHIFT at T+4, then a fresh frame
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      start = (k == 1);
      sin   = good[k];
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    e_dout = '0; e_syn = '0; e_err = 1'b0;
    frm8 = 0; cor8 = 0; frm2 = 0; cor2 = 0; ovr_m = 1'b0;
    chk_all("rst_mid", 1'b0, 1'b0);
    frame("post_rst", good, 1, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
